// File: rtl/vga_mem_arbiter_pkg.sv
// Shared widths and the in-flight owner encoding for the VGA/CPU memory arbiter.
package vga_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_CPU
    } owner_t;

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// Bundles the renderer, CPU and memory-port signals around the arbiter.
// master = arbiter side, slave = renderer/CPU/memory side.
interface vga_mem_arbiter_if;
    import vga_arb_pkg::*;

    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_valid;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vga_rdata, vga_valid, cpu_gnt, cpu_rvalid, cpu_rdata,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vga_rdata, vga_valid, cpu_gnt, cpu_rvalid, cpu_rdata,
               mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/vga_mem_arbiter_wait_counter.sv
// Saturating wait counter with synchronous clear; sat flags that MAX was reached.
module arb_wait_counter #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int           W     = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != MAX_V)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign sat = (count_reg == MAX_V);

endmodule

// File: rtl/vga_mem_arbiter.sv
// Arbitrates the single memory port between the VGA renderer (priority) and the CPU.
// Optional CPU starvation guard: define VGA_ARB_STARVE_GUARD_EN.
module vga_mem_arbiter
    import vga_arb_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              botonRST,
    vga_mem_arbiter_if.master bus
);

    owner_t            owner_reg, owner_next;
    logic [ADDR_W-1:0] flight_addr_reg, flight_addr_next;
    logic [ADDR_W-1:0] vga_tag_reg;
    logic              tag_ok_reg;
    logic [DATA_W-1:0] vga_rdata_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;

    logic              vga_pending;
    logic              cpu_starved;
    logic              issue_vga;
    logic              gnt;
    logic              cpu_wr;
    logic              capture_vga;
    logic              wr_hit_tag;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_we;
    logic [DATA_W-1:0] issue_wdata;

`ifdef VGA_ARB_STARVE_GUARD_EN
    logic wait_sat;

    arb_wait_counter #(
        .MAX (CPU_MAX_WAIT)
    ) u_wait (
        .clk   (clk),
        .rst_n (botonRST),
        .inc   (bus.cpu_req && !gnt),
        .clr   (gnt),
        .sat   (wait_sat)
    );

    assign cpu_starved = wait_sat;
`else
    // Strict VGA priority: the CPU never overrides a pending fetch.
    assign cpu_starved = (CPU_MAX_WAIT < 0);
`endif

    always_comb begin
        vga_pending      = 1'b0;
        issue_vga        = 1'b0;
        gnt              = 1'b0;
        issue_addr       = '0;
        issue_we         = 1'b0;
        issue_wdata      = '0;
        owner_next       = OWN_NONE;
        flight_addr_next = flight_addr_reg;

        vga_pending = !(tag_ok_reg && (vga_tag_reg == bus.vga_addr))
                   && !((owner_reg == OWN_VGA) && (flight_addr_reg == bus.vga_addr));

        // Reset low forces the port idle, so nothing issues from here.
        issue_vga = botonRST && vga_pending && !(bus.cpu_req && cpu_starved);
        gnt       = botonRST && bus.cpu_req && !issue_vga;

        if (issue_vga) begin
            issue_addr       = bus.vga_addr;
            owner_next       = OWN_VGA;
            flight_addr_next = bus.vga_addr;
        end else if (gnt) begin
            issue_addr  = bus.cpu_addr;
            issue_we    = bus.cpu_we;
            issue_wdata = bus.cpu_wdata;
            if (!bus.cpu_we) begin
                owner_next       = OWN_CPU;
                flight_addr_next = bus.cpu_addr;
            end
        end
    end

    // A CPU write landing on the in-flight VGA address makes that result stale.
    assign cpu_wr      = gnt && bus.cpu_we;
    assign capture_vga = (owner_reg == OWN_VGA)
                      && !(cpu_wr && (bus.cpu_addr == flight_addr_reg));
    assign wr_hit_tag  = cpu_wr && (bus.cpu_addr == vga_tag_reg);

    always_ff @(posedge clk or negedge botonRST) begin
        if (!botonRST) begin
            owner_reg       <= OWN_NONE;
            flight_addr_reg <= '0;
            vga_tag_reg     <= '0;
            tag_ok_reg      <= 1'b0;
            vga_rdata_reg   <= '0;
            cpu_rdata_reg   <= '0;
        end else begin
            owner_reg       <= owner_next;
            flight_addr_reg <= flight_addr_next;
            if (capture_vga) begin
                vga_rdata_reg <= bus.mem_rdata;
                vga_tag_reg   <= flight_addr_reg;
                tag_ok_reg    <= 1'b1;
            end else if (wr_hit_tag) begin
                tag_ok_reg <= 1'b0;
            end
            if (owner_reg == OWN_CPU) begin
                cpu_rdata_reg <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr   = issue_addr;
    assign bus.mem_we     = issue_we;
    assign bus.mem_wdata  = issue_wdata;
    assign bus.cpu_gnt    = gnt;
    assign bus.cpu_rvalid = (owner_reg == OWN_CPU);
    assign bus.cpu_rdata  = (owner_reg == OWN_CPU) ? bus.mem_rdata : cpu_rdata_reg;
    assign bus.vga_rdata  = vga_rdata_reg;
    assign bus.vga_valid  = tag_ok_reg && (vga_tag_reg == bus.vga_addr);

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter with a registered-read 256x32 memory model.
// Starvation expectations follow VGA_ARB_STARVE_GUARD_EN.
module tb_vga_mem_arbiter;
    import vga_arb_pkg::*;

    localparam int MAX_WAIT = 15;

    logic clk = 1'b0;
    logic botonRST;
    logic mem_init;
    int   total = 0;
    int   bad   = 0;

    logic [DATA_W-1:0] mem     [256];
    logic [DATA_W-1:0] ref_mem [256];
    logic [DATA_W-1:0] cpu_exp [$];
    logic [DATA_W-1:0] vga_exp [$];

    always #5 clk = ~clk;

    vga_mem_arbiter_if bus ();

    vga_mem_arbiter #(
        .CPU_MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .botonRST (botonRST),
        .bus      (bus)
    );

    function automatic logic [DATA_W-1:0] init_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 16) ? 32'hDEAD_BEEF : {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_do(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, output int waited);
        logic [DATA_W-1:0] exp;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        waited = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.cpu_gnt) begin
                waited = c;
                break;
            end
            tick();
        end
        total++;
        if (waited < 0) begin
            bad++;
            $display("FAIL cpu_grant_timeout addr=%h got no grant, required a grant", addr);
            bus.cpu_req = 1'b0;
            return;
        end
        total++;
        if (bus.mem_we !== we || bus.mem_addr !== addr || (we && bus.mem_wdata !== wdata)) begin
            bad++;
            $display("FAIL cpu_issue got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, we, addr, wdata);
        end
        if (we) ref_mem[addr] = wdata;
        else    cpu_exp.push_back(ref_mem[addr]);
        tick();
        bus.cpu_req = 1'b0;
        if (!we) begin
            @(negedge clk);
            exp = cpu_exp.pop_front();
            total++;
            if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== exp) begin
                bad++;
                $display("FAIL cpu_read addr=%h got rvalid=%b data=%h required rvalid=1 data=%h",
                         addr, bus.cpu_rvalid, bus.cpu_rdata, exp);
            end
            tick();
        end
        $display("cpu %s addr=%h wdata=%h waited=%0d", we ? "wr" : "rd", addr, wdata, waited);
    endtask

    task automatic wait_vga(input int budget, output int cyc);
        logic [DATA_W-1:0] exp;
        cyc = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.vga_valid) begin
                cyc = c;
                break;
            end
            tick();
        end
        exp = vga_exp.pop_front();
        total++;
        if (cyc < 0) begin
            bad++;
            $display("FAIL vga_valid_timeout addr=%h got valid=0, required valid=1", bus.vga_addr);
        end else begin
            total++;
            if (bus.vga_rdata !== exp) begin
                bad++;
                $display("FAIL vga_rdata addr=%h got %h required %h", bus.vga_addr, bus.vga_rdata, exp);
            end
            tick();
        end
        $display("vga addr=%h valid after %0d cycles", bus.vga_addr, cyc);
    endtask

    task automatic test_reset();
        int seen;
        botonRST      = 1'b0;
        mem_init      = 1'b1;
        bus.vga_addr  = 8'h10;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 8'h33;
        bus.cpu_wdata = 32'h1234_5678;
        repeat (3) tick();
        @(negedge clk);
        total++;
        if ({bus.cpu_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_port got gnt=%b we=%b addr=%h wdata=%h required all zero",
                     bus.cpu_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        total++;
        if ({bus.vga_valid, bus.vga_rdata, bus.cpu_rvalid, bus.cpu_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_data got vvalid=%b vdata=%h rvalid=%b rdata=%h required all zero",
                     bus.vga_valid, bus.vga_rdata, bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick();
        mem_init    = 1'b0;
        bus.cpu_req = 1'b0;
        botonRST    = 1'b1;
        vga_exp.push_back(ref_mem[8'h10]);
        seen = -1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (bus.cpu_gnt !== 1'b0) begin
                bad++;
                $display("FAIL release_gnt cycle=%0d got %b required 0", c, bus.cpu_gnt);
            end
            if (c == 0) begin
                total++;
                if (bus.mem_addr !== 8'h10) begin
                    bad++;
                    $display("FAIL release_issue got addr=%h required 10", bus.mem_addr);
                end
            end
            if (bus.vga_valid) begin
                seen = c;
                break;
            end
            tick();
        end
        total++;
        if (seen != 2) begin
            bad++;
            $display("FAIL release_latency got valid at cycle %0d required 2", seen);
        end
        total++;
        if (bus.vga_rdata !== vga_exp.pop_front()) begin
            bad++;
            $display("FAIL release_rdata got %h required deadbeef", bus.vga_rdata);
        end
        tick();
    endtask

    task automatic test_cpu_write_read();
        int w;
        cpu_do(1'b1, 8'h20, 32'h0000_55AA, w);
        total++;
        if (w != 0 || mem[8'h20] !== 32'h0000_55AA) begin
            bad++;
            $display("FAIL write_20 got wait=%0d mem=%h required wait=0 mem=000055aa", w, mem[8'h20]);
        end
        cpu_do(1'b0, 8'h20, '0, w);
        total++;
        if (w != 0) begin
            bad++;
            $display("FAIL read_20_wait got %0d required 0", w);
        end
        @(negedge clk);
        total++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0000_55AA) begin
            bad++;
            $display("FAIL rdata_hold got rvalid=%b data=%h required rvalid=0 data=000055aa",
                     bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick();
    endtask

    task automatic test_vga_cpu_conflict();
        int w;
        bus.vga_addr = 8'h40;
        vga_exp.push_back(ref_mem[8'h40]);
        cpu_do(1'b0, 8'h21, '0, w);
        total++;
        if (w != 1) begin
            bad++;
            $display("FAIL conflict_wait got %0d required 1", w);
        end
        wait_vga(1, w);
    endtask

    task automatic test_write_invalidate();
        int w;
        bus.vga_addr = 8'h30;
        vga_exp.push_back(ref_mem[8'h30]);
        wait_vga(5, w);
        cpu_do(1'b1, 8'h30, 32'hCAFE_F00D, w);
        vga_exp.push_back(32'hCAFE_F00D);
        @(negedge clk);
        total++;
        if (bus.vga_valid !== 1'b0) begin
            bad++;
            $display("FAIL invalidate_drop got valid=%b required 0", bus.vga_valid);
        end
        tick();
        wait_vga(4, w);
        total++;
        if (w != 1) begin
            bad++;
            $display("FAIL refetch_latency got %0d required 1", w);
        end
    endtask

    task automatic test_inflight_discard();
        int w;
        bus.vga_addr = 8'h50;
        cpu_do(1'b1, 8'h50, 32'h0BAD_F00D, w);
        vga_exp.push_back(32'h0BAD_F00D);
        @(negedge clk);
        total++;
        if (bus.vga_valid !== 1'b0) begin
            bad++;
            $display("FAIL discard_stale got valid=%b data=%h required valid=0", bus.vga_valid, bus.vga_rdata);
        end
        tick();
        wait_vga(5, w);
        total++;
        if (w != 1) begin
            bad++;
            $display("FAIL discard_refetch got %0d required 1", w);
        end
    endtask

    task automatic test_starve();
        int first;
        logic [DATA_W-1:0] exp;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'h22;
        first = -1;
        for (int c = 0; c < 40; c++) begin
            bus.vga_addr = 8'(8'h80 + c);
            @(negedge clk);
            if (bus.cpu_gnt) begin
                first = c;
                break;
            end
            tick();
        end
        total++;
`ifdef VGA_ARB_STARVE_GUARD_EN
        if (first != MAX_WAIT) begin
            bad++;
            $display("FAIL starve_grant got cycle %0d required %0d", first, MAX_WAIT);
        end
`else
        if (first != -1) begin
            bad++;
            $display("FAIL starve_nogrant got grant at cycle %0d required none", first);
        end
`endif
        if (first < 0) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (bus.cpu_gnt) begin
                    first = 40 + c;
                    break;
                end
                tick();
            end
        end
        total++;
        if (first < 0 || bus.mem_addr !== 8'h22) begin
            bad++;
            $display("FAIL starve_release got grant=%0d addr=%h required grant at addr 22", first, bus.mem_addr);
        end else begin
            cpu_exp.push_back(ref_mem[8'h22]);
            tick();
            bus.cpu_req = 1'b0;
            @(negedge clk);
            exp = cpu_exp.pop_front();
            total++;
            if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== exp) begin
                bad++;
                $display("FAIL starve_read got rvalid=%b data=%h required rvalid=1 data=%h",
                         bus.cpu_rvalid, bus.cpu_rdata, exp);
            end
        end
        bus.cpu_req = 1'b0;
        tick();
        $display("starve grant cycle=%0d", first);
    endtask

    task automatic test_back_to_back();
        int w;
        logic [DATA_W-1:0] exp;
        bus.vga_addr = 8'h10;
        vga_exp.push_back(ref_mem[8'h10]);
        wait_vga(5, w);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'h20;
        @(negedge clk);
        total++;
        if (bus.cpu_gnt !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gnt0 got %b required 1", bus.cpu_gnt);
        end
        cpu_exp.push_back(ref_mem[8'h20]);
        tick();
        bus.cpu_addr = 8'h21;
        @(negedge clk);
        exp = cpu_exp.pop_front();
        total++;
        if (bus.cpu_gnt !== 1'b1 || bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== exp) begin
            bad++;
            $display("FAIL b2b_first got gnt=%b rvalid=%b data=%h required gnt=1 rvalid=1 data=%h",
                     bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_rdata, exp);
        end
        cpu_exp.push_back(ref_mem[8'h21]);
        tick();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        exp = cpu_exp.pop_front();
        total++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== exp) begin
            bad++;
            $display("FAIL b2b_second got rvalid=%b data=%h required rvalid=1 data=%h",
                     bus.cpu_rvalid, bus.cpu_rdata, exp);
        end
        tick();
        $display("b2b reads 20,21 done");
    endtask

    task automatic test_reset_midread();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 8'h21;
        bus.cpu_wdata = 32'hFFFF_0001;
        @(negedge clk);
        total++;
        if (bus.cpu_gnt !== 1'b1) begin
            bad++;
            $display("FAIL midread_gnt got %b required 1", bus.cpu_gnt);
        end
        tick();
        botonRST   = 1'b0;
        bus.cpu_we = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.cpu_rvalid, bus.cpu_rdata, bus.vga_valid, bus.vga_rdata} !== '0) begin
            bad++;
            $display("FAIL midread_data got rvalid=%b rdata=%h vvalid=%b vdata=%h required all zero",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.vga_valid, bus.vga_rdata);
        end
        total++;
        if ({bus.cpu_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
            bad++;
            $display("FAIL midread_port got gnt=%b we=%b addr=%h wdata=%h required all zero",
                     bus.cpu_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        bus.cpu_req = 1'b0;
        tick();
        botonRST = 1'b1;
        repeat (3) tick();
        $display("reset during read done");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        test_reset();
        test_cpu_write_read();
        test_vga_cpu_conflict();
        test_write_invalidate();
        test_inflight_discard();
        test_starve();
        test_back_to_back();
        test_reset_midread();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired, required bench completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Shares the single-port, 256×32 text/character memory between two requesters. The first is the VGA character renderer, which reads one word per character cell and has real-time priority. The second is the processor data port, which reads and writes through a req/gnt handshake. The block sits between the display path's character address/data pair and the memory's only port. It holds the last fetched VGA word so the renderer sees stable data across a character cell.

## Interface
- ADDR_W, 8, memory word address width
- DATA_W, 32, memory word width
- CPU_MAX_WAIT, 15, cycles a pending CPU request may wait before it takes priority; only used with the guard enabled
- clk  in  1  system clock
- botonRST  in  1  reset, asynchronous, active-low
- vga_addr  in  ADDR_W  character word address requested by the renderer
- vga_rdata  out  DATA_W  held word for the last completed VGA fetch
- vga_valid  out  1  vga_rdata corresponds to the current vga_addr
- cpu_req  in  1  CPU access request; held high until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle grant; CPU inputs are sampled this cycle
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid
- cpu_rdata  out  DATA_W  CPU read data, held until the next read completes
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one cycle after the address is issued

## Operation
- Registers:
  - vga_tag (ADDR_W): address of the word in vga_rdata.
  - tag_ok: vga_rdata is valid for vga_tag.
  - inflight owner: NONE, VGA or CPU, plus the address of the in-flight read.
- vga_pending: asserted when neither condition below holds:
  - tag_ok = 1 and vga_tag == vga_addr;
  - a VGA read of vga_addr is already in flight.
- Issue rule (combinational, one access per cycle):
  1. If the CPU has starved (guard enabled and cpu_req waited ≥ CPU_MAX_WAIT), grant the CPU.
  2. Otherwise, if vga_pending, issue a VGA read.
  3. Otherwise, if cpu_req, grant the CPU.
  4. Otherwise, stay idle with mem_we = 0.
- CPU grant: cpu_gnt = 1, mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata.
  - A write completes in the grant cycle.
  - A read sets the inflight owner to CPU.
- Capture, in the cycle after a read is issued:
  - Owner VGA: vga_rdata ← mem_rdata, vga_tag ← issued address, tag_ok ← 1.
  - Owner CPU: cpu_rdata ← mem_rdata, cpu_rvalid pulses.
  - A new access may issue in the same cycle, so the block is fully pipelined.
- CPU write to an address equal to vga_tag or to an in-flight VGA read: tag_ok ← 0 and the in-flight VGA result is discarded. The VGA word is then re-fetched, so the display never shows stale data.
- vga_valid = tag_ok and (vga_tag == vga_addr).

## Timing
- VGA read latency: vga_addr changes in cycle N with no CPU starvation; the read issues in N; the capture edge is at the end of N+1; vga_valid = 1 from N+2.
- CPU read: cpu_gnt in cycle G; cpu_rvalid and cpu_rdata in G+1.
- CPU write: memory updated at the end of G.
- Back-to-back grants are allowed. If cpu_req stays high after a grant, the next request is arbitrated in the following cycle.
- vga_addr changing while its read is in flight: the capture still updates vga_tag to the old address, vga_valid stays 0, and a new fetch issues.
- Reset (botonRST low, any time):
  - vga_rdata = 0, cpu_rdata = 0, vga_tag = 0, tag_ok = 0, vga_valid = 0, cpu_rvalid = 0.
  - cpu_gnt = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0; these are forced while reset is low.
  - In-flight reads are dropped and the wait counter is cleared.

## Configuration
- VGA_ARB_STARVE_GUARD_EN defined:
  - A saturating wait counter counts cycles with cpu_req = 1 and cpu_gnt = 0, and clears on grant.
  - At CPU_MAX_WAIT the CPU wins over a pending VGA fetch for one access.
- Not defined: strict VGA priority and no counter. The CPU can be blocked indefinitely if vga_addr changes every cycle.

## Structure
- Package vga_arb_pkg holds ADDR_W and DATA_W defaults and the owner_t enum {OWN_NONE, OWN_VGA, OWN_CPU}.
- One sub-module, arb_wait_counter (saturating counter with clear), is instantiated only under VGA_ARB_STARVE_GUARD_EN.

## Test plan
- Reset release with vga_addr = 0x10 and mem[0x10] = 0xDEADBEEF → vga_valid = 1 and vga_rdata = 0xDEADBEEF by cycle 2 after release; cpu_gnt = 0 throughout.
- cpu_req write 0x55AA to 0x20 while vga_addr is stable and valid → cpu_gnt the same cycle, mem_we = 1, mem[0x20] = 0x55AA; a following CPU read of 0x20 gives cpu_rvalid one cycle after grant with 0x55AA.
- vga_addr change and CPU read in the same cycle → VGA issues first; the CPU is granted the next cycle with rvalid one cycle after its grant.
- CPU write to 0x30 while vga_tag = 0x30 → vga_valid drops and a refetch occurs; vga_rdata shows the new value within 3 cycles.
- Guard enabled, vga_addr toggling every cycle, cpu_req held → cpu_gnt after exactly CPU_MAX_WAIT waiting cycles; with the guard disabled there is no grant.
- botonRST asserted one cycle after a CPU read grant → no cpu_rvalid; all outputs at their reset values.
